// File: rtl/whitening_sequencer.sv
// Initiator-side sequencer for the whitening block: arms it, requests samples, buffers Z1..Z4.
// Optional per-channel energy accumulators are built when WHITENING_STATS_EN is defined.
module whitening_sequencer #(
  parameter int N_SAMPLES   = 1024,
  parameter int ADDR_W      = 10,
  parameter int DATA_W      = 16,
  parameter int TIMEOUT_CYC = 4095
) (
  input  logic                     CLK_sequencer,
  input  logic                     RST_sequencer,
  input  logic                     Start,
  input  logic                     Whitening_busy,
  input  logic signed [DATA_W-1:0] Z1,
  input  logic signed [DATA_W-1:0] Z2,
  input  logic signed [DATA_W-1:0] Z3,
  input  logic signed [DATA_W-1:0] Z4,
  output logic                     GO_whitening,
  output logic                     New_one,
  input  logic [ADDR_W-1:0]        Rd_addr,
  output logic signed [DATA_W-1:0] Rd_Z1,
  output logic signed [DATA_W-1:0] Rd_Z2,
  output logic signed [DATA_W-1:0] Rd_Z3,
  output logic signed [DATA_W-1:0] Rd_Z4,
  output logic                     Seq_busy,
  output logic                     Seq_done,
  output logic                     Timeout_err,
  output logic [ADDR_W:0]          Sample_cnt
`ifdef WHITENING_STATS_EN
  ,
  output logic [2*DATA_W+ADDR_W-1:0] Energy1,
  output logic [2*DATA_W+ADDR_W-1:0] Energy2,
  output logic [2*DATA_W+ADDR_W-1:0] Energy3,
  output logic [2*DATA_W+ADDR_W-1:0] Energy4
`endif
);

  localparam int TMO_W  = $clog2(TIMEOUT_CYC + 1);
  localparam int WORD_W = 4 * DATA_W;

  typedef enum logic [2:0] {
    S_IDLE, S_ARM, S_REQ, S_WAIT_HI, S_WAIT_LO, S_CAPT, S_DONE
  } state_t;

  state_t             state_reg, state_next;
  logic [TMO_W-1:0]   tmo_reg;
  logic [ADDR_W:0]    cnt_reg;
  logic [ADDR_W:0]    cnt_inc;
  logic               err_reg;
  logic               tmo_hit;
  logic               abort;
  logic               start_run;
  logic               wr_en;

  assign cnt_inc   = cnt_reg + 1'b1;
  assign tmo_hit   = (tmo_reg == TMO_W'(TIMEOUT_CYC));
  assign start_run = Start && ((state_reg == S_IDLE) || (state_reg == S_DONE));
  // Reset suppresses the write combinationally so an aborted capture never lands.
  assign wr_en     = (state_reg == S_CAPT) && !RST_sequencer;

  always_comb begin
    state_next = state_reg;
    abort      = 1'b0;
    case (state_reg)
      S_IDLE, S_DONE: if (Start) state_next = S_ARM;
      S_ARM: begin
        // Blind window: busy may not have risen yet in the first two ARM cycles.
        if ((tmo_reg >= TMO_W'(2)) && !Whitening_busy) state_next = S_REQ;
        else if (tmo_hit) begin state_next = S_DONE; abort = 1'b1; end
      end
      S_REQ: state_next = S_WAIT_HI;
      S_WAIT_HI: begin
        if (Whitening_busy) state_next = S_WAIT_LO;
        else if (tmo_hit) begin state_next = S_DONE; abort = 1'b1; end
      end
      S_WAIT_LO: begin
        if (!Whitening_busy) state_next = S_CAPT;
        else if (tmo_hit) begin state_next = S_DONE; abort = 1'b1; end
      end
      S_CAPT: state_next = (cnt_inc == (ADDR_W+1)'(N_SAMPLES)) ? S_DONE : S_REQ;
      default: state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK_sequencer) begin
    if (RST_sequencer) begin
      state_reg <= S_IDLE;
      tmo_reg   <= '0;
      cnt_reg   <= '0;
      err_reg   <= 1'b0;
    end else begin
      state_reg <= state_next;
      if (state_next != state_reg)
        tmo_reg <= '0;
      else if ((state_reg == S_ARM) || (state_reg == S_WAIT_HI) || (state_reg == S_WAIT_LO))
        tmo_reg <= tmo_reg + 1'b1;
      if (start_run) begin
        cnt_reg <= '0;
        err_reg <= 1'b0;
      end else if (state_reg == S_CAPT) begin
        cnt_reg <= cnt_inc;
      end
      if (abort) err_reg <= 1'b1;
    end
  end

  // Sample buffer: write-first is not wanted, a same-address read returns the old word.
  logic [WORD_W-1:0] mem [2**ADDR_W];
  logic [WORD_W-1:0] rd_word_reg;
  logic              rd_ok_reg;

  always_ff @(posedge CLK_sequencer) begin
    if (wr_en) mem[cnt_reg[ADDR_W-1:0]] <= {Z1, Z2, Z3, Z4};
    rd_word_reg <= mem[Rd_addr];
  end

  always_ff @(posedge CLK_sequencer) begin
    if (RST_sequencer) rd_ok_reg <= 1'b0;
    else               rd_ok_reg <= ({1'b0, Rd_addr} < (ADDR_W+1)'(N_SAMPLES));
  end

  assign Rd_Z1 = rd_ok_reg ? rd_word_reg[4*DATA_W-1 -: DATA_W] : '0;
  assign Rd_Z2 = rd_ok_reg ? rd_word_reg[3*DATA_W-1 -: DATA_W] : '0;
  assign Rd_Z3 = rd_ok_reg ? rd_word_reg[2*DATA_W-1 -: DATA_W] : '0;
  assign Rd_Z4 = rd_ok_reg ? rd_word_reg[1*DATA_W-1 -: DATA_W] : '0;

  assign GO_whitening = !RST_sequencer && (state_reg != S_IDLE) && (state_reg != S_DONE);
  assign New_one      = !RST_sequencer && (state_reg == S_REQ);
  assign Seq_busy     = (state_reg != S_IDLE) && (state_reg != S_DONE);
  assign Seq_done     = (state_reg == S_DONE);
  assign Timeout_err  = err_reg;
  assign Sample_cnt   = cnt_reg;

`ifdef WHITENING_STATS_EN
  localparam int E_W = 2*DATA_W + ADDR_W;
  logic signed [DATA_W-1:0] z_in [4];
  logic [E_W-1:0]           energy_reg [4];

  assign z_in[0] = Z1;
  assign z_in[1] = Z2;
  assign z_in[2] = Z3;
  assign z_in[3] = Z4;

  for (genvar gi = 0; gi < 4; gi++) begin : g_energy
    logic signed [2*DATA_W-1:0] sq;
    assign sq = z_in[gi] * z_in[gi];
    always_ff @(posedge CLK_sequencer) begin
      if (RST_sequencer || start_run) energy_reg[gi] <= '0;
      else if (state_reg == S_CAPT)   energy_reg[gi] <= energy_reg[gi] + {{ADDR_W{1'b0}}, sq};
    end
  end

  assign Energy1 = energy_reg[0];
  assign Energy2 = energy_reg[1];
  assign Energy3 = energy_reg[2];
  assign Energy4 = energy_reg[3];
`endif

endmodule
